// File: rtl/rv_buf_n.sv
// rv_buf_n: valid/ready elastic buffer with configurable depth and width.
// It breaks the forward (valid/data) and backward (ready) timing paths and still
// sustains one word per cycle. It also reports occupancy, raises an almost-full flag
// and supports a synchronous flush.
//
// Ports:
//   i_clk           clock, every flop updates on the rising edge
//   i_rst           synchronous active-high reset
//   i_flush         synchronous clear of all stored entries
//   i_datain        upstream data
//   i_datain_val    upstream valid
//   o_datain_rdy    buffer can accept (count != depth)
//   o_dataout       head-of-buffer data (0 while empty)
//   o_dataout_val   head entry valid (count != 0)
//   i_dataout_rdy   downstream ready
//   o_count         number of stored entries
//   o_almost_full   count >= af_level
module rv_buf_n #(
  parameter int unsigned wd       = 4,
  parameter int unsigned depth    = 4,
  parameter int unsigned af_level = 3,
  parameter int unsigned cw       = $clog2(depth + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic [wd-1:0] i_datain,
  input  logic          i_datain_val,
  output logic          o_datain_rdy,
  output logic [wd-1:0] o_dataout,
  output logic          o_dataout_val,
  input  logic          i_dataout_rdy,
  output logic [cw-1:0] o_count,
  output logic          o_almost_full
);

  localparam int unsigned pw = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [cw-1:0] c_depth = cw'(depth);
  localparam logic [cw-1:0] c_af    = cw'(af_level);
  localparam logic [pw-1:0] c_last  = pw'(depth - 1);

  logic [wd-1:0] r_mem [depth];
  logic [pw-1:0] r_wptr, r_rptr;
  logic [cw-1:0] r_count;
  logic          r_af;

  logic          w_push, w_pop;
  logic [pw-1:0] w_wptr_d, w_rptr_d;
  logic [cw-1:0] w_count_d;

  // Handshake outputs depend only on registered occupancy. No input reaches an output.
  assign o_datain_rdy  = (r_count != c_depth);
  assign o_dataout_val = (r_count != '0);
  assign o_dataout     = o_dataout_val ? r_mem[r_rptr] : '0;
  assign o_count       = r_count;
  assign o_almost_full = r_af;

  assign w_push = i_datain_val & o_datain_rdy;
  assign w_pop  = o_dataout_val & i_dataout_rdy;

  always_comb begin
    w_wptr_d  = r_wptr;
    w_rptr_d  = r_rptr;
    w_count_d = r_count;
    if (i_flush) begin
      // Flush discards any push or pop that happens in the same cycle.
      w_wptr_d  = '0;
      w_rptr_d  = '0;
      w_count_d = '0;
    end else begin
      if (w_push) w_wptr_d = (r_wptr == c_last) ? '0 : r_wptr + 1'b1;
      if (w_pop)  w_rptr_d = (r_rptr == c_last) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   w_count_d = r_count + 1'b1;
        2'b01:   w_count_d = r_count - 1'b1;
        default: w_count_d = r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_af    <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_d;
      r_rptr  <= w_rptr_d;
      r_count <= w_count_d;
      r_af    <= (w_count_d >= c_af);
    end
  end

  // Storage needs no reset. Stale entries are never visible because of the count
  // and the output gating.
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush && w_push) r_mem[r_wptr] <= i_datain;
  end

endmodule

// File: tb/tb_rv_buf_n.sv
// Testbench for rv_buf_n. It drives directed and random handshakes and checks
// every cycle against a queue-based reference model.
module tb_rv_buf_n;

  localparam int unsigned WD    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AF    = 3;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          rst, flush, datain_val, datain_rdy, dataout_val, dataout_rdy, almost_full;
  logic [WD-1:0] datain, dataout;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  logic [WD-1:0] model_q [$];

  rv_buf_n #(
    .wd       (WD),
    .depth    (DEPTH),
    .af_level (AF),
    .cw       (CW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_flush       (flush),
    .i_datain      (datain),
    .i_datain_val  (datain_val),
    .o_datain_rdy  (datain_rdy),
    .o_dataout     (dataout),
    .o_dataout_val (dataout_val),
    .i_dataout_rdy (dataout_rdy),
    .o_count       (count),
    .o_almost_full (almost_full)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the clock, update the model, then check all outputs.
  task automatic step(input logic v, input logic [WD-1:0] d, input logic dr,
                      input logic fl, input logic rs);
    bit m_push, m_pop;
    int sz;
    rst         = rs;
    flush       = fl;
    datain_val  = v;
    datain      = d;
    dataout_rdy = dr;
    m_push = v && (model_q.size() < DEPTH);
    m_pop  = dr && (model_q.size() > 0);
    @(posedge clk);
    #1;
    if (rs || fl) begin
      model_q.delete();
    end else begin
      if (m_pop)  void'(model_q.pop_front());
      if (m_push) model_q.push_back(d);
    end
    sz = model_q.size();
    check_eq("count", 32'(count), 32'(sz));
    check_eq("dataout_val", 32'(dataout_val), 32'(sz != 0));
    check_eq("datain_rdy", 32'(datain_rdy), 32'(sz != DEPTH));
    check_eq("almost_full", 32'(almost_full), 32'(sz >= AF));
    if (sz != 0) check_eq("dataout", 32'(dataout), 32'(model_q[0]));
    if (rs) check_eq("rst_dataout", 32'(dataout), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; datain_val = 1'b0; datain = '0; dataout_rdy = 1'b0;

    // Reset, then stay idle.
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) step(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

    // Fill under back-pressure, then hold word 5 while the buffer is full.
    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    // Drain from full. Word 5 stays offered until it is taken once.
    step(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

    // Flush mid-stream together with a push and a pop.
    for (int i = 10; i <= 12; i++) step(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd13, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

    // Reset during a simultaneous push and pop at count 2.
    step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd4, 1'b1, 1'b0, 1'b1);
    step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
